// File: rtl/branch_target_buffer.sv
// Two-way set-associative branch target buffer: zero-latency lookup on the fetch PC, trained from EX.
// Optional write-through forwarding of a same-cycle update is enabled by defining BTB_BYPASS_EN.
module branch_target_buffer #(
  parameter int SET_ADDR_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PL_stall,
  input  logic [31:0] pc,
  output logic        btb_hit,
  output logic [1:0]  btb_kind,
  output logic [31:0] btb_target,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic [1:0]  upd_kind,
  input  logic [31:0] upd_target,
  input  logic        inv_all
);
  localparam int TAG_WIDTH = 30 - SET_ADDR_WIDTH;
  localparam int SETS = 1 << SET_ADDR_WIDTH;
  localparam logic [1:0] KIND_RSVD = 2'd3;

  logic [1:0]           valid_q [SETS];
  logic [1:0]           valid_d [SETS];
  logic [SETS-1:0]      lru_q;
  logic [SETS-1:0]      lru_d;
  logic [TAG_WIDTH-1:0] tag_q   [SETS][2];
  logic [TAG_WIDTH-1:0] tag_d   [SETS][2];
  logic [1:0]           kind_q  [SETS][2];
  logic [1:0]           kind_d  [SETS][2];
  logic [29:0]          tgt_q   [SETS][2];
  logic [29:0]          tgt_d   [SETS][2];

  logic [SET_ADDR_WIDTH-1:0] lk_idx;
  logic [SET_ADDR_WIDTH-1:0] up_idx;
  logic [TAG_WIDTH-1:0]      lk_tag;
  logic [TAG_WIDTH-1:0]      up_tag;
  logic [1:0]                lk_match;
  logic [1:0]                up_match;
  logic                      lk_hit;
  logic                      lk_way;
  logic                      wr_way;
  logic                      wr_en;
  logic                      data_we;
  logic                      unused_low_bits;

  assign lk_idx = pc[SET_ADDR_WIDTH+1:2];
  assign lk_tag = pc[31:SET_ADDR_WIDTH+2];
  assign up_idx = upd_pc[SET_ADDR_WIDTH+1:2];
  assign up_tag = upd_pc[31:SET_ADDR_WIDTH+2];
  assign unused_low_bits = ^{pc[1:0], upd_pc[1:0], upd_target[1:0]};

  // Reserved kind and flash-invalidate both drop the write entirely.
  assign wr_en   = upd_en && !inv_all && (upd_kind != KIND_RSVD);
  assign data_we = wr_en && !rst;

  always_comb begin
    lk_match = '0;
    up_match = '0;
    for (int w = 0; w < 2; w++) begin
      lk_match[w] = valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag);
      up_match[w] = valid_q[up_idx][w] && (tag_q[up_idx][w] == up_tag);
    end
    lk_hit = |lk_match;
    lk_way = !lk_match[0];
  end

  always_comb begin
    if (up_match[0])               wr_way = 1'b0;
    else if (up_match[1])          wr_way = 1'b1;
    else if (!valid_q[up_idx][0])  wr_way = 1'b0;
    else if (!valid_q[up_idx][1])  wr_way = 1'b1;
    else                           wr_way = lru_q[up_idx];
  end

  always_comb begin
    btb_hit    = 1'b0;
    btb_kind   = 2'd0;
    btb_target = 32'd0;
`ifdef BTB_BYPASS_EN
    if (wr_en && (upd_pc[31:2] == pc[31:2])) begin
      btb_hit    = 1'b1;
      btb_kind   = upd_kind;
      btb_target = {upd_target[31:2], 2'b00};
    end else
`endif
    if (lk_hit) begin
      btb_hit    = 1'b1;
      btb_kind   = kind_q[lk_idx][lk_way];
      btb_target = {tgt_q[lk_idx][lk_way], 2'b00};
    end
  end

  // Update's LRU assignment is applied last so it wins over a same-set lookup hit.
  always_comb begin
    valid_d = valid_q;
    lru_d   = lru_q;
    if (lk_hit && !PL_stall) lru_d[lk_idx] = ~lk_way;
    if (wr_en) begin
      valid_d[up_idx][wr_way] = 1'b1;
      lru_d[up_idx]           = ~wr_way;
    end
    if (inv_all) begin
      for (int s = 0; s < SETS; s++) valid_d[s] = 2'b00;
    end
  end

  always_comb begin
    tag_d  = tag_q;
    kind_d = kind_q;
    tgt_d  = tgt_q;
    if (data_we) begin
      tag_d[up_idx][wr_way]  = up_tag;
      kind_d[up_idx][wr_way] = upd_kind;
      tgt_d[up_idx][wr_way]  = upd_target[31:2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) valid_q[s] <= 2'b00;
      lru_q <= '0;
    end else begin
      valid_q <= valid_d;
      lru_q   <= lru_d;
    end
  end

  // Payload storage carries no reset; valid bits alone qualify it.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    kind_q <= kind_d;
    tgt_q  <= tgt_d;
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer against a recency-ordered entry-list model.
module tb_branch_target_buffer;
  localparam int SAW = 4;

  logic        clk = 1'b0;
  logic        rst, PL_stall, upd_en, inv_all;
  logic [31:0] pc, upd_pc, upd_target;
  logic [1:0]  upd_kind;
  logic        btb_hit;
  logic [1:0]  btb_kind;
  logic [31:0] btb_target;

  always #5 clk = ~clk;

  branch_target_buffer #(.SET_ADDR_WIDTH(SAW)) dut (
    .clk(clk), .rst(rst), .PL_stall(PL_stall), .pc(pc),
    .btb_hit(btb_hit), .btb_kind(btb_kind), .btb_target(btb_target),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_kind(upd_kind),
    .upd_target(upd_target), .inv_all(inv_all)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [29:0] key;
    logic [1:0]  kind;
    logic [29:0] tgt;
    int unsigned stamp;
  } ent_t;

  ent_t        m[$];
  int unsigned now_t = 0;

  function automatic int find(input logic [29:0] key);
    foreach (m[i]) if (m[i].key == key) return i;
    return -1;
  endfunction

  function automatic void check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
    end
  endfunction

  function automatic void mlook(input logic [31:0] p, output logic h, output logic [1:0] k,
                                output logic [31:0] t);
    int i;
    h = 1'b0; k = 2'd0; t = 32'd0;
`ifdef BTB_BYPASS_EN
    if (upd_en && !inv_all && upd_kind != 2'd3 && upd_pc[31:2] == p[31:2]) begin
      h = 1'b1; k = upd_kind; t = {upd_target[31:2], 2'b00};
      return;
    end
`endif
    i = find(p[31:2]);
    if (i >= 0) begin
      h = 1'b1; k = m[i].kind; t = {m[i].tgt, 2'b00};
    end
  endfunction

  // Victim is the least recently touched entry among those sharing the set.
  function automatic void mupdate(input logic [29:0] key, input logic [1:0] k,
                                  input logic [29:0] t, input int unsigned st);
    int i, n, old;
    ent_t e;
    i = find(key);
    if (i >= 0) begin
      m[i].kind = k; m[i].tgt = t; m[i].stamp = st;
      return;
    end
    n = 0; old = -1;
    foreach (m[j]) if (m[j].key[SAW-1:0] == key[SAW-1:0]) begin
      n++;
      if (old < 0 || m[j].stamp < m[old].stamp) old = j;
    end
    if (n >= 2) m.delete(old);
    e.key = key; e.kind = k; e.tgt = t; e.stamp = st;
    m.push_back(e);
  endfunction

  always @(posedge clk) begin : model
    logic touch;
    int   i;
    if (rst) begin
      m.delete();
    end else begin
      touch = (find(pc[31:2]) >= 0) && !PL_stall;
      now_t += 2;
      if (inv_all) m.delete();
      else if (upd_en && upd_kind != 2'd3) mupdate(upd_pc[31:2], upd_kind, upd_target[31:2], now_t);
      i = find(pc[31:2]);
      if (touch && i >= 0 && m[i].stamp < now_t - 1) m[i].stamp = now_t - 1;
    end
  end

  logic        e_hit;
  logic [1:0]  e_kind;
  logic [31:0] e_tgt;

  always @(negedge clk) begin
    if (!rst) begin
      mlook(pc, e_hit, e_kind, e_tgt);
      check("model_hit", {31'b0, btb_hit}, {31'b0, e_hit});
      check("model_kind", {30'b0, btb_kind}, {30'b0, e_kind});
      check("model_target", btb_target, e_tgt);
    end
  end

  task automatic look(input logic [31:0] p, input logic st);
    pc = p; PL_stall = st;
  endtask

  task automatic upd(input logic [31:0] a, input logic [1:0] k, input logic [31:0] t);
    upd_en = 1'b1; upd_pc = a; upd_kind = k; upd_target = t;
  endtask

  task automatic next();
    @(posedge clk); #1;
    upd_en = 1'b0; inv_all = 1'b0; PL_stall = 1'b0;
  endtask

  task automatic lit(input string nm, input logic h, input logic [1:0] k, input logic [31:0] t);
    @(negedge clk);
    check({nm, "_hit"}, {31'b0, btb_hit}, {31'b0, h});
    check({nm, "_kind"}, {30'b0, btb_kind}, {30'b0, k});
    check({nm, "_target"}, btb_target, t);
  endtask

  task automatic probe(input string nm, input logic [31:0] p, input logic h,
                       input logic [1:0] k, input logic [31:0] t);
    look(p, 1'b1); lit(nm, h, k, t); next();
  endtask

  initial begin
    rst = 1'b1; PL_stall = 1'b0; upd_en = 1'b0; inv_all = 1'b0;
    pc = 32'h0; upd_pc = 32'h0; upd_kind = 2'd0; upd_target = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    look(32'h100, 1'b0); lit("reset_miss", 1'b0, 2'd0, 32'h0); next();
    upd(32'h100, 2'd0, 32'h80); look(32'h100, 1'b1); next();
    probe("first_fill", 32'h100, 1'b1, 2'd0, 32'h80);

    upd(32'h140, 2'd1, 32'h1000); next();
    look(32'h100, 1'b0); lit("alias_touch", 1'b1, 2'd0, 32'h80); next();
    upd(32'h180, 2'd2, 32'h2000); next();
    probe("evicted_140", 32'h140, 1'b0, 2'd0, 32'h0);
    probe("kept_100", 32'h100, 1'b1, 2'd0, 32'h80);
    probe("new_180", 32'h180, 1'b1, 2'd2, 32'h2000);

    upd(32'h100, 2'd3, 32'hDEAD0); next();
    probe("kind3_ignored", 32'h100, 1'b1, 2'd0, 32'h80);

    look(32'h100, 1'b1); next();
    upd(32'h1C0, 2'd1, 32'h3000); next();
    probe("stall_evict_100", 32'h100, 1'b0, 2'd0, 32'h0);
    probe("stall_keep_180", 32'h180, 1'b1, 2'd2, 32'h2000);
    probe("stall_new_1c0", 32'h1C0, 1'b1, 2'd1, 32'h3000);

    upd(32'h400, 2'd0, 32'h40); inv_all = 1'b1; next();
    probe("inv_drop_400", 32'h400, 1'b0, 2'd0, 32'h0);
    probe("inv_clear_180", 32'h180, 1'b0, 2'd0, 32'h0);
    probe("inv_clear_1c0", 32'h1C0, 1'b0, 2'd0, 32'h0);

    upd(32'h200, 2'd1, 32'h300); next();
    upd(32'h200, 2'd2, 32'h0); next();
    probe("overwrite_200", 32'h200, 1'b1, 2'd2, 32'h0);
    upd(32'h240, 2'd0, 32'h44); next();
    probe("other_way_200", 32'h200, 1'b1, 2'd2, 32'h0);
    probe("other_way_240", 32'h240, 1'b1, 2'd0, 32'h44);

    upd(32'h500, 2'd0, 32'h600); look(32'h500, 1'b1);
`ifdef BTB_BYPASS_EN
    lit("bypass_same", 1'b1, 2'd0, 32'h600);
`else
    lit("bypass_same", 1'b0, 2'd0, 32'h0);
`endif
    next();
    probe("bypass_next", 32'h500, 1'b1, 2'd0, 32'h600);
    probe("bypass_evict_200", 32'h200, 1'b0, 2'd0, 32'h0);

    upd(32'h540, 2'd0, 32'h700); look(32'h240, 1'b0); next();
    probe("race_victim_240", 32'h240, 1'b0, 2'd0, 32'h0);
    probe("race_new_540", 32'h540, 1'b1, 2'd0, 32'h700);
    upd(32'h580, 2'd1, 32'h800); next();
    probe("race_lru_500", 32'h500, 1'b0, 2'd0, 32'h0);
    probe("race_lru_540", 32'h540, 1'b1, 2'd0, 32'h700);

    for (int s = 0; s < 16; s++) begin
      upd(32'h1000 + 32'(s) * 4, 2'(s % 3), 32'h4000 + 32'(s) * 16); next();
    end
    for (int s = 0; s < 16; s++) begin
      look(32'h1000 + 32'(s) * 4, 1'(s % 2)); next();
    end
    probe("sets_fill_7", 32'h101C, 1'b1, 2'd1, 32'h4070);

    rst = 1'b1; upd(32'h600, 2'd1, 32'h900); next();
    rst = 1'b0;
    probe("midreset_600", 32'h600, 1'b0, 2'd0, 32'h0);
    probe("midreset_540", 32'h540, 1'b0, 2'd0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
